// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, fetch constants, branch opcodes and the
// fetch-queue entry layout.
package pipeline_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Branch/jump opcodes decoded by EXE to form br_taken.
  localparam logic [5:0] OP_BEZ = 6'b101000;
  localparam logic [5:0] OP_BNE = 6'b101001;
  localparam logic [5:0] OP_JMP = 6'b101010;

  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO with synchronous flush. The head is read from
// registered storage through a registered pointer, so nothing from the write
// side reaches rdata in the same cycle. rdata is forced to zero when empty.
module fetch_queue #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // A push into a full queue is legal only when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller: PC register, prefetch queue feeding ID over
// valid/ready, redirect handling from EXE and an accepted-instruction counter.
module fetch_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned N        = pipeline_pkg::N,
  parameter int unsigned DEPTH    = 2,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  input  logic         br_taken,
  input  logic [N-1:0] br_addr,
  output logic         if_valid,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] if_pc_plus4,
  input  logic         id_ready,
  output logic [15:0]  fetch_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [N-1:0]   pc_q, pc_d, pc_plus4;
  logic [15:0]    cnt_q;
  logic           push, pop;
  logic [2*N-1:0] q_head;
  logic [CW-1:0]  q_count;
  logic           q_full, q_empty;

  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + N'(PC_STEP);
  assign pop       = ~q_empty & id_ready;
  assign push      = ~br_taken & ((q_count < CW'(DEPTH)) | pop);

  fetch_queue #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (br_taken),
    .wdata ({imem_instr, pc_plus4}),
    .rdata (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign if_valid    = ~q_empty;
  // Queue already zeroes its head when empty; NOP keeps the intent explicit.
  assign if_instr    = q_empty ? N'(NOP_INSTR) : q_head[2*N-1:N];
  assign if_pc_plus4 = q_head[N-1:0];
  assign fetch_cnt   = cnt_q;

  // Next PC: redirect wins, then sequential fetch, else hold.
  always_comb begin
    pc_d = pc_q;
    if (br_taken)  pc_d = {br_addr[N-1:2], 2'b00};
    else if (push) pc_d = pc_plus4;
  end

  // PC register and saturating accepted-instruction count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (pop && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Queue full flag must agree with its occupancy count.
  always_ff @(posedge clk) begin
    if (!rst) assert (q_full == (q_count == CW'(DEPTH)));
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational memory model where
// word k holds k + 0x100.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_instr;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        if_valid;
  logic [31:0] if_instr, if_pc_plus4;
  logic        id_ready;
  logic [15:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr >> 2) + 32'h100;

  fetch_sequencer #(
    .N        (32),
    .DEPTH    (2),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_plus4 (if_pc_plus4),
    .id_ready    (id_ready),
    .fetch_cnt   (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; br_taken = 1'b0; br_addr = '0; id_ready = 1'b0;
    #1;
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_cnt", {16'b0, fetch_cnt}, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc4", if_pc_plus4, 32'h0);
    step(); step();
    rst = 1'b0;

    // First word appears one cycle after release.
    step();
    check("first_valid", {31'b0, if_valid}, 32'h1);
    check("first_instr", if_instr, 32'h100);
    check("first_pc4", if_pc_plus4, 32'h4);
    check("first_addr", imem_addr, 32'h4);

    // Stall: queue fills to two and PC freezes at 8 with head held.
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem_addr, 32'h8);
      check("stall_instr", if_instr, 32'h100);
      check("stall_valid", {31'b0, if_valid}, 32'h1);
    end

    // Release: one instruction per cycle, no gap.
    id_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("stream_instr", if_instr, 32'h100 + k);
      check("stream_pc4", if_pc_plus4, 32'(4 * k + 4));
      check("stream_cnt", {16'b0, fetch_cnt}, 32'(k));
    end

    // Stall while full, then redirect to a misaligned target.
    id_ready = 1'b0;
    step(); step();
    check("full_hold", if_instr, 32'h10A);
    br_taken = 1'b1; br_addr = 32'h103;
    step();
    check("redir_valid", {31'b0, if_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_instr", if_instr, 32'h0);
    check("redir_cnt", {16'b0, fetch_cnt}, 32'd10);
    br_taken = 1'b0;
    step();
    check("tgt_valid", {31'b0, if_valid}, 32'h1);
    check("tgt_instr", if_instr, 32'h140);
    check("tgt_pc4", if_pc_plus4, 32'h104);

    // Redirect to the top word; PC+4 wraps to zero.
    br_taken = 1'b1; br_addr = 32'hFFFF_FFFE;
    step();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", {31'b0, if_valid}, 32'h0);
    br_taken = 1'b0;
    step();
    check("wrap_instr", if_instr, 32'h4000_00FF);
    check("wrap_pc4", if_pc_plus4, 32'h0);
    check("wrap_next", imem_addr, 32'h0);

    // Back-to-back redirects: last one wins, queue stays empty.
    br_taken = 1'b1; br_addr = 32'h200;
    step();
    br_addr = 32'h300;
    step();
    check("b2b_addr", imem_addr, 32'h300);
    check("b2b_valid", {31'b0, if_valid}, 32'h0);
    br_taken = 1'b0;
    step();
    check("b2b_instr", if_instr, 32'h1C0);
    check("b2b_pc4", if_pc_plus4, 32'h304);

    // Redirect coincident with a pop still counts the pop once.
    id_ready = 1'b1; br_taken = 1'b1; br_addr = 32'h40;
    step();
    check("coin_cnt", {16'b0, fetch_cnt}, 32'd11);
    check("coin_valid", {31'b0, if_valid}, 32'h0);
    br_taken = 1'b0; id_ready = 1'b0;
    step();
    check("coin_instr", if_instr, 32'h110);
    check("coin_pc4", if_pc_plus4, 32'h44);
    step();
    check("coin_full_addr", imem_addr, 32'h48);

    // Asynchronous reset between edges with two entries queued.
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, if_valid}, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_cnt", {16'b0, fetch_cnt}, 32'h0);
    check("arst_instr", if_instr, 32'h0);
    step();
    rst = 1'b0;

    // Run the counter up to saturation, then keep popping.
    id_ready = 1'b1;
    n = 0;
    while (fetch_cnt != 16'hFFFF && n < 70000) begin
      step();
      n++;
    end
    check("sat_reached", {16'b0, fetch_cnt}, 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_hold", {16'b0, fetch_cnt}, 32'hFFFF);
      check("sat_valid", {31'b0, if_valid}, 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
